alu_seq: RTL and testbench

//  Registered, parametrised ALU for the multicycle CPU datapath. Adds iterative shifts and an optional

---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_seq_comb.sv | 54 +++++
 rtl/alu_seq.sv | 178 +++++++++++++++++
 tb/tb_alu_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
//------------------------------------------------------------------------------
// alu_seq_pkg : opcode and FSM state encodings shared by the alu_seq files.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_XOR  = 4'd2,
    OP_SLT  = 4'd3,
    OP_AND  = 4'd4,
    OP_NAND = 4'd5,
    OP_NOR  = 4'd6,
    OP_OR   = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_MUL  = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_comb.sv
//------------------------------------------------------------------------------
// alu_seq_comb : combinational ops 0-7 with ADD/SUB-only flags.
// Revision     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_zero,
  output logic             o_overflow
);

  logic             w_sub;
  logic             w_arith;
  logic             w_cout;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_sum;

  assign w_sub   = (i_op == OP_SUB);
  assign w_arith = (i_op == OP_ADD) || w_sub;
  assign w_bx    = w_sub ? ~i_b : i_b;
  assign {w_cout, w_sum} = {1'b0, i_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_sub};

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD, OP_SUB: o_result = w_sum;
      OP_XOR:         o_result = i_a ^ i_b;
      // Direct signed compare stays correct when A-B would overflow
      OP_SLT:         o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_AND:         o_result = i_a & i_b;
      OP_NAND:        o_result = ~(i_a & i_b);
      OP_NOR:         o_result = ~(i_a | i_b);
      OP_OR:          o_result = i_a | i_b;
      default:        o_result = '0;
    endcase
  end

  assign o_carry    = w_arith & w_cout;
  assign o_zero     = w_arith & (w_sum == '0);
  assign o_overflow = w_arith & (i_a[WIDTH-1] == w_bx[WIDTH-1]) &
                      (w_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
//------------------------------------------------------------------------------
// alu_seq  : registered ALU with iterative shifts and optional shift-add MUL.
//            Define ALU_SEQ_MUL_EN to build command 11 as MUL (else illegal).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       command,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = SHAMT_W + 1;

  state_e           r_state;
  state_e           w_next;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_zero;
  logic             r_ovf;
  logic             r_illegal;

  logic             w_accept;
  logic             w_is_shift;
  logic             w_is_mul;
  logic             w_illegal;
  logic             w_shamt_zero;
  logic             w_last;
  logic [CNT_W-1:0] w_shamt;
  logic [WIDTH-1:0] w_comb_res;
  logic [WIDTH-1:0] w_shift_next;
  logic             w_c;
  logic             w_z;
  logic             w_o;

  assign w_accept     = in_valid && (r_state == S_IDLE);
  assign w_is_shift   = is_shift(command);
  assign w_shamt      = {1'b0, operandB[SHAMT_W-1:0]};
  assign w_shamt_zero = (operandB[SHAMT_W-1:0] == '0);
  assign w_last       = (r_cnt == CNT_W'(1));

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] r_b;
  assign w_is_mul = (command == OP_MUL);
`else
  assign w_is_mul = 1'b0;
`endif

  assign w_illegal = (command > OP_MUL) || ((command == OP_MUL) && !w_is_mul);

  alu_seq_comb #(
    .WIDTH      (WIDTH)
  ) u_comb (
    .i_op       (command),
    .i_a        (operandA),
    .i_b        (operandB),
    .o_result   (w_comb_res),
    .o_carry    (w_c),
    .o_zero     (w_z),
    .o_overflow (w_o)
  );

  always_comb begin
    w_shift_next = r_a >> 1;
    case (r_op)
      OP_SLL:  w_shift_next = r_a << 1;
      OP_SRA:  w_shift_next = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
      default: w_shift_next = r_a >> 1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if ((w_is_shift && !w_shamt_zero) || w_is_mul) w_next = S_BUSY;
          else                                            w_next = S_DONE;
        end
      end
      S_BUSY:  if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= '0;
      r_a       <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_b       <= '0;
`endif
    end else if (w_accept) begin
      r_op      <= command;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
      if (w_illegal) begin
        r_result  <= '0;
        r_illegal <= 1'b1;
      end else if (w_is_shift) begin
        // Preloading the result covers the shamt==0 bypass to DONE
        r_a      <= operandA;
        r_result <= operandA;
        r_cnt    <= w_shamt;
`ifdef ALU_SEQ_MUL_EN
      end else if (w_is_mul) begin
        r_a      <= operandA;
        r_b      <= operandB;
        r_result <= '0;
        r_cnt    <= CNT_W'(WIDTH);
`endif
      end else begin
        r_result <= w_comb_res;
        r_carry  <= w_c;
        r_zero   <= w_z;
        r_ovf    <= w_o;
      end
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt - CNT_W'(1);
`ifdef ALU_SEQ_MUL_EN
      if (r_op == OP_MUL) begin
        if (r_b[0]) r_result <= r_result + r_a;
        r_a <= r_a << 1;
        r_b <= r_b >> 1;
      end else
`endif
      begin
        r_a      <= w_shift_next;
        r_result <= w_shift_next;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign carryout  = r_carry;
  assign zero      = r_zero;
  assign overflow  = r_ovf;
  assign illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
//------------------------------------------------------------------------------
// tb_alu_seq : self-checking bench for alu_seq (WIDTH=32).
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq;

  localparam int W = 32;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   command;
  logic [W-1:0] operandA;
  logic [W-1:0] operandB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carryout;
  logic         zero;
  logic         overflow;
  logic         illegal;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .command   (command),
    .operandA  (operandA),
    .operandB  (operandB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carryout  (carryout),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         o;
    logic         ill;
    int           lat;
  } exp_t;

  typedef struct {
    logic [3:0]   cmd;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk_exp(input logic [W-1:0] res, input logic c, input logic z,
                                  input logic o, input logic ill, input int lat);
    exp_t e;
    e.res = res; e.c = c; e.z = z; e.o = o; e.ill = ill; e.lat = lat;
    return e;
  endfunction

  function automatic vec_t mk(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                              input exp_t e);
    vec_t v;
    v.cmd = cmd; v.a = a; v.b = b; v.e = e;
    return v;
  endfunction

  // Independent reference: textbook flag equations and native operators
  function automatic exp_t model(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [W:0]   s;
    logic [63:0]  p;
    int           sh;
    e  = mk_exp('0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    sh = int'(b[4:0]);
    case (cmd)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[W-1:0]; e.c = s[W]; e.z = (e.res == '0);
        e.o = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      4'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        e.res = s[W-1:0]; e.c = s[W]; e.z = (e.res == '0);
        e.o = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      4'd2:  e.res = a ^ b;
      4'd3:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  e.res = a & b;
      4'd5:  e.res = ~(a & b);
      4'd6:  e.res = ~(a | b);
      4'd7:  e.res = a | b;
      4'd8:  begin e.res = a << sh; e.lat = sh + 1; end
      4'd9:  begin e.res = a >> sh; e.lat = sh + 1; end
      4'd10: begin e.res = W'($signed(a) >>> sh); e.lat = sh + 1; end
      4'd11: begin
        if (MUL_EN) begin
          p = {32'd0, a} * {32'd0, b};
          e.res = p[W-1:0]; e.lat = W + 1;
        end else e.ill = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic run_op(input string name, input logic [3:0] cmd, input logic [W-1:0] a,
                        input logic [W-1:0] b, input exp_t e, input int hold);
    exp_t got;
    int   lat;
    @(negedge clk);
    chk({name, ".in_ready"}, in_ready, 1);
    out_ready = (hold == 0);
    in_valid  = 1'b1; command = cmd; operandA = a; operandB = b;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; command = 4'($urandom); operandA = $urandom; operandB = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    got = sb.pop_front();
    if (!out_valid) begin
      checks++; failures++;
      $display("FAIL %s.timeout actual=no_out_valid required=out_valid", name);
    end else begin
      chk({name, ".result"},   result,   got.res);
      chk({name, ".carry"},    carryout, got.c);
      chk({name, ".zero"},     zero,     got.z);
      chk({name, ".overflow"}, overflow, got.o);
      chk({name, ".illegal"},  illegal,  got.ill);
      chk({name, ".latency"},  lat,      got.lat);
    end
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; command = 4'd7; operandA = 32'h0F0F_0F0F; operandB = 32'h1111_1111;
      @(posedge clk); #1;
      chk({name, ".hold_result"},   result,    got.res);
      chk({name, ".hold_valid"},    out_valid, 1);
      chk({name, ".hold_in_ready"}, in_ready,  0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({name, ".valid_drop"}, out_valid, 0);
    chk({name, ".idle"},       in_ready,  1);
  endtask

  initial begin
    exp_t e;
    logic [3:0] rc;
    logic [W-1:0] ra, rb;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    command = '0; operandA = '0; operandB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.result",    result,    0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.flags",     {carryout, zero, overflow, illegal}, 0);
    @(negedge clk); reset = 1'b0;
    #1 chk("rst.in_ready", in_ready, 1);

    tbl.push_back(mk(4'd0,  32'h7FFF_FFFF, 32'h0000_0001, mk_exp(32'h8000_0000, 0, 0, 1, 0, 1)));
    tbl.push_back(mk(4'd1,  32'd5,         32'd5,         mk_exp(32'h0000_0000, 1, 1, 0, 0, 1)));
    tbl.push_back(mk(4'd3,  32'h8000_0000, 32'h0000_0001, mk_exp(32'h0000_0001, 0, 0, 0, 0, 1)));
    tbl.push_back(mk(4'd10, 32'h8000_0010, 32'h0000_0004, mk_exp(32'hF800_0001, 0, 0, 0, 0, 5)));
    tbl.push_back(mk(4'd8,  32'h1234_5678, 32'h0000_0020, mk_exp(32'h1234_5678, 0, 0, 0, 0, 1)));
    tbl.push_back(mk(4'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0, mk_exp(32'hFF00_FF00, 0, 0, 0, 0, 1)));
    tbl.push_back(mk(4'd4,  32'hF0F0_F0F0, 32'h0FF0_0FF0, mk_exp(32'h00F0_00F0, 0, 0, 0, 0, 1)));
    tbl.push_back(mk(4'd5,  32'hF0F0_F0F0, 32'h0FF0_0FF0, mk_exp(32'hFF0F_FF0F, 0, 0, 0, 0, 1)));
    tbl.push_back(mk(4'd6,  32'hF0F0_F0F0, 32'h0FF0_0FF0, mk_exp(32'h000F_000F, 0, 0, 0, 0, 1)));
    tbl.push_back(mk(4'd7,  32'hF0F0_F0F0, 32'h0FF0_0FF0, mk_exp(32'hFFF0_FFF0, 0, 0, 0, 0, 1)));
    tbl.push_back(mk(4'd9,  32'h8000_0000, 32'h0000_001F, mk_exp(32'h0000_0001, 0, 0, 0, 0, 32)));
    tbl.push_back(mk(4'd8,  32'h0000_0001, 32'hFFFF_FFE3, mk_exp(32'h0000_0008, 0, 0, 0, 0, 4)));
    tbl.push_back(mk(4'd1,  32'h0000_0000, 32'h0000_0001, mk_exp(32'hFFFF_FFFF, 0, 0, 0, 0, 1)));
    tbl.push_back(mk(4'd1,  32'h8000_0000, 32'h0000_0001, mk_exp(32'h7FFF_FFFF, 1, 0, 1, 0, 1)));
    tbl.push_back(mk(4'd0,  32'hFFFF_FFFF, 32'h0000_0001, mk_exp(32'h0000_0000, 1, 1, 0, 0, 1)));
    tbl.push_back(mk(4'd3,  32'h7FFF_FFFF, 32'h8000_0000, mk_exp(32'h0000_0000, 0, 0, 0, 0, 1)));
    tbl.push_back(mk(4'd13, 32'h1234_5678, 32'h1111_1111, mk_exp(32'h0000_0000, 0, 0, 0, 1, 1)));
    tbl.push_back(mk(4'd3,  32'd5,         32'd7,         mk_exp(32'h0000_0001, 0, 0, 0, 0, 1)));
    if (MUL_EN)
      tbl.push_back(mk(4'd11, 32'h0001_0003, 32'h0000_0005, mk_exp(32'h0005_000F, 0, 0, 0, 0, 33)));
    else
      tbl.push_back(mk(4'd11, 32'h0001_0003, 32'h0000_0005, mk_exp(32'h0000_0000, 0, 0, 0, 1, 1)));

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].e, 0);

    for (int i = 0; i < 16; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      run_op($sformatf("rnd%0d_op%0d", i, rc), rc, ra, rb, model(rc, ra, rb), 0);
    end

    // Consumer stalls in DONE while a competing command is offered
    run_op("hold", 4'd0, 32'd2, 32'd3, mk_exp(32'd5, 0, 0, 0, 0, 1), 10);

    // Async reset in the middle of a long iterative op
    @(negedge clk);
    in_valid = 1'b1;
    if (MUL_EN) begin command = 4'd11; operandA = 32'h0001_0003; operandB = 32'h0000_0005; end
    else        begin command = 4'd9;  operandA = 32'hFFFF_FFFF; operandB = 32'h0000_001F; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst.result",    result,    0);
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.flags",     {carryout, zero, overflow, illegal}, 0);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("midrst.no_valid", out_valid, 0);
      chk("midrst.in_ready", in_ready,  1);
    end
    e = mk_exp(32'd5, 0, 0, 0, 0, 1);
    run_op("post_rst_add", 4'd0, 32'd2, 32'd3, e, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
